// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: RV32 major opcodes, operand-forward select encoding,
// hazard FSM states and the register-dependence match helper.
package cpu_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // x0 is hardwired to zero, so a write to it never creates a dependence.
  function automatic logic reg_match(input logic       used,
                                     input logic       wen,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
    return used && wen && (rd != 5'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_ctrl_op_class.sv
// Combinational register-usage decode of the instruction sitting in ID.
module op_class
  import cpu_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [4:0] i_rd,
  output logic       o_uses_rs1,
  output logic       o_uses_rs2,
  output logic       o_writes_rd,
  output logic       o_is_load
);

  logic w_wr;

  always_comb begin
    o_uses_rs1 = 1'b0;
    o_uses_rs2 = 1'b0;
    o_is_load  = 1'b0;
    w_wr       = 1'b0;
    case (i_opcode)
      OP_OP:     begin o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1; w_wr = 1'b1; end
      OP_OPIMM:  begin o_uses_rs1 = 1'b1; w_wr = 1'b1; end
      OP_LOAD:   begin o_uses_rs1 = 1'b1; w_wr = 1'b1; o_is_load = 1'b1; end
      OP_JALR:   begin o_uses_rs1 = 1'b1; w_wr = 1'b1; end
      OP_STORE:  begin o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1; end
      OP_BRANCH: begin o_uses_rs1 = 1'b1; o_uses_rs2 = 1'b1; end
      OP_LUI:    w_wr = 1'b1;
      OP_JAL:    w_wr = 1'b1;
      default:   ;
    endcase
  end

  assign o_writes_rd = w_wr && (i_rd != 5'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / dependence stalls, redirect flushes, operand
// forwarding selects and a saturating stall counter. Define HAZARD_FWD_EN for forwarding.
module hazard_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        ex_redirect,
  output logic        stall_if,
  output logic        flush_id,
  output logic        bubble_ex,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic w_uses_rs1, w_uses_rs2, w_writes_rd, w_is_load;

  op_class u_op_class (
    .i_opcode    (id_opcode),
    .i_rd        (id_rd),
    .o_uses_rs1  (w_uses_rs1),
    .o_uses_rs2  (w_uses_rs2),
    .o_writes_rd (w_writes_rd),
    .o_is_load   (w_is_load)
  );

  state_e      r_state;
  logic [4:0]  r_ex_rd, r_mem_rd;
  logic        r_ex_wen, r_ex_is_load, r_mem_wen;
  logic [15:0] r_stall_cnt;

  logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;
  logic w_load_use, w_hazard, w_flush, w_stall, w_bubble;
  fwd_sel_e w_fwd_a, w_fwd_b;

  assign w_ex_m1    = reg_match(w_uses_rs1, r_ex_wen,  r_ex_rd,  id_rs1);
  assign w_ex_m2    = reg_match(w_uses_rs2, r_ex_wen,  r_ex_rd,  id_rs2);
  assign w_mem_m1   = reg_match(w_uses_rs1, r_mem_wen, r_mem_rd, id_rs1);
  assign w_mem_m2   = reg_match(w_uses_rs2, r_mem_wen, r_mem_rd, id_rs2);
  assign w_load_use = r_ex_is_load && (w_ex_m1 || w_ex_m2);

`ifdef HAZARD_FWD_EN
  assign w_hazard = w_load_use;

  always_comb begin
    w_fwd_a = FWD_RF;
    w_fwd_b = FWD_RF;
    if (w_ex_m1 && !r_ex_is_load) w_fwd_a = FWD_EXMEM;
    else if (w_mem_m1)            w_fwd_a = FWD_MEMWB;
    if (w_ex_m2 && !r_ex_is_load) w_fwd_b = FWD_EXMEM;
    else if (w_mem_m2)            w_fwd_b = FWD_MEMWB;
  end
`else
  // Without bypass paths any in-flight producer blocks ID until it reaches WB.
  assign w_hazard = w_load_use || w_ex_m1 || w_ex_m2 || w_mem_m1 || w_mem_m2;
  assign w_fwd_a  = FWD_RF;
  assign w_fwd_b  = FWD_RF;
`endif

  assign w_flush  = ex_redirect || (r_state == FLUSH);
  assign w_stall  = w_hazard && !w_flush;
  assign w_bubble = w_stall || w_flush;

  assign stall_if  = !rst && w_stall;
  assign flush_id  = !rst && w_flush;
  assign bubble_ex = !rst && w_bubble;
  assign fwd_a     = (rst || w_bubble) ? 2'b00 : w_fwd_a;
  assign fwd_b     = (rst || w_bubble) ? 2'b00 : w_fwd_b;
  assign stall_cnt = rst ? 16'h0000 : r_stall_cnt;

  // ID -> EX -> MEM shadow of destination info, FSM and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_ex_rd      <= 5'd0;
      r_ex_wen     <= 1'b0;
      r_ex_is_load <= 1'b0;
      r_mem_rd     <= 5'd0;
      r_mem_wen    <= 1'b0;
      r_stall_cnt  <= 16'h0000;
    end else begin
      case (r_state)
        RUN:     if (ex_redirect) r_state <= FLUSH;
                 else if (w_hazard) r_state <= STALL;
        STALL:   if (ex_redirect) r_state <= FLUSH;
                 else if (w_hazard) r_state <= STALL;
                 else r_state <= RUN;
        FLUSH:   r_state <= ex_redirect ? FLUSH : RUN;
        default: r_state <= RUN;
      endcase
      r_mem_rd  <= r_ex_rd;
      r_mem_wen <= r_ex_wen;
      if (w_bubble) begin
        r_ex_rd      <= 5'd0;
        r_ex_wen     <= 1'b0;
        r_ex_is_load <= 1'b0;
      end else begin
        r_ex_rd      <= id_rd;
        r_ex_wen     <= w_writes_rd;
        r_ex_is_load <= w_is_load;
      end
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

endmodule
